// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Optional leading-zero blanking output enabled by BIN2BCD_LZB_EN.
module bin2bcd_seq #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4,
  parameter int CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  done,
  output logic                  busy,
`ifdef BIN2BCD_LZB_EN
  output logic [DIGITS-1:0]     digit_blank,
`endif
  output logic                  bcd_en
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int SR_W  = ACC_W + BIN_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [BIN_W-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   bcd_q, bcd_d;
  logic               done_q, done_d;

  logic [ACC_W-1:0]   adj;
  logic [SR_W-1:0]    sr_nx;
  logic [ACC_W-1:0]   acc_nx;
  logic [BIN_W-1:0]   sh_nx;

  // add-3 on every nibble >= 5, then shift the whole register left
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    sr_nx  = {adj, sh_q} << 1;
    acc_nx = sr_nx[SR_W-1:BIN_W];
    sh_nx  = sr_nx[BIN_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          sh_d    = bin_in;
          cnt_d   = CNT_W'(BIN_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = acc_nx;
        sh_d  = sh_nx;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = acc_nx;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

`ifdef BIN2BCD_LZB_EN
  logic [DIGITS-1:0] blank_q, blank_d, blank_nx;
  logic              zero_run;

  // bit i set when digit i and every higher digit are zero
  always_comb begin
    blank_nx = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run && (acc_nx[4*i +: 4] == 4'd0);
      blank_nx[i] = zero_run;
    end
    blank_d = blank_q;
    if (state_q == SHIFT && cnt_q == CNT_W'(1))
      blank_d = blank_nx;
  end

  always_ff @(posedge clk) begin
    if (reset)
      blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
    else
      blank_q <= blank_d;
  end

  assign digit_blank = blank_q;
`endif

  assign bcd_out = bcd_q;
  assign done    = done_q;
  assign busy    = (state_q != IDLE);
  assign bcd_en  = (state_q == IDLE);

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed steps plus random values.
// Reference digits come from decimal division of the input value.
module tb_bin2bcd_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [11:0] bin_in;
  logic [15:0] bcd_out;
  logic        done;
  logic        busy;
  logic        bcd_en;
`ifdef BIN2BCD_LZB_EN
  logic [3:0]  digit_blank;
`endif

  int total = 0;
  int bad   = 0;

  bin2bcd_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bin_in      (bin_in),
    .bcd_out     (bcd_out),
    .done        (done),
    .busy        (busy),
`ifdef BIN2BCD_LZB_EN
    .digit_blank (digit_blank),
`endif
    .bcd_en      (bcd_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_bcd(input int v);
    ref_bcd = 16'((v / 1000) % 10) << 12
            | 16'((v / 100) % 10) << 8
            | 16'((v / 10) % 10) << 4
            | 16'(v % 10);
  endfunction

  function automatic logic [3:0] ref_blank(input int v);
    ref_blank = {v < 1000, v < 100, v < 10, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // edges until done is seen, bounded
  task automatic wait_done(output int edges);
    edges = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      edges++;
      if (done === 1'b1) break;
    end
  endtask

  task automatic conv(input string tag, input int v);
    int n;
    bin_in = 12'(v);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    wait_done(n);
    chk({tag, "_lat"}, n, 12);
    chk({tag, "_bcd"}, bcd_out, ref_bcd(v));
`ifdef BIN2BCD_LZB_EN
    chk({tag, "_blank"}, digit_blank, ref_blank(v));
`endif
    tick();
    chk({tag, "_done_lo"}, done, 0);
    chk({tag, "_bcd_en"}, bcd_en, 1);
  endtask

  initial begin
    int n;
    int seen;
    int v;
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_bcd", bcd_out, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bcd_en", bcd_en, 1);
`ifdef BIN2BCD_LZB_EN
    chk("rst_blank", digit_blank, 4'b1110);
`endif

    // basic conversion with handshake check
    bin_in = 12'd1234;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("t2_busy", busy, 1);
    chk("t2_bcd_en", bcd_en, 0);
    wait_done(n);
    chk("t2_lat", n, 12);
    chk("t2_bcd", bcd_out, 16'h1234);
    tick();
    chk("t2_done_lo", done, 0);
    chk("t2_bcd_en_hi", bcd_en, 1);

    conv("zero", 0);
    conv("max", 4095);
    conv("v999", 999);
    conv("v1000", 1000);
    conv("v42", 42);
    conv("v305", 305);

    // start while busy is ignored
    bin_in = 12'd2048;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    bin_in = 12'd7;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done === 1'b1) begin
        seen++;
        chk("busy_bcd", bcd_out, 16'h2048);
      end
    end
    chk("busy_ndone", seen, 1);

    // reset aborts a conversion
    bin_in = 12'd4095;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("abort_bcd", bcd_out, 0);
    chk("abort_idle", bcd_en, 1);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done === 1'b1) seen++;
    end
    chk("abort_nodone", seen, 0);
    conv("post_abort", 42);

    // start held high: back-to-back, each samples its own bin_in
    bin_in = 12'd321;
    start  = 1'b1;
    tick();
    bin_in = 12'd3210;
    wait_done(n);
    chk("b2b_lat1", n, 12);
    chk("b2b_bcd1", bcd_out, 16'h0321);
    tick();
    tick();
    start = 1'b0;
    chk("b2b_busy2", busy, 1);
    wait_done(n);
    chk("b2b_lat2", n, 12);
    chk("b2b_bcd2", bcd_out, 16'h3210);
    tick();

    for (int r = 0; r < 12; r++) begin
      v = int'($urandom_range(0, 4095));
      conv("rand", v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
